// File: rtl/pwm_seq_pkg.sv
// Shared constants for the Wishbone PWM duty sequencer: state encoding,
// default timer-window address map and the bus timeout.
package pwm_seq_pkg;

    localparam logic [31:0] DefBaseAddr = 32'h3000_0000;
    localparam logic [31:0] DefStride   = 32'h0000_1000;
    localparam logic [31:0] DefRegOff   = 32'h0000_0008;
    localparam int unsigned DefTimeout  = 16;

    localparam int unsigned StW = 3;

    localparam logic [StW-1:0] StIdle  = 3'd0;
    localparam logic [StW-1:0] StLatch = 3'd1;
    localparam logic [StW-1:0] StReq   = 3'd2;
    localparam logic [StW-1:0] StWait  = 3'd3;
    localparam logic [StW-1:0] StNext  = 3'd4;
    localparam logic [StW-1:0] StDone  = 3'd5;

endpackage

// File: rtl/pwm_seq_tick.sv
// Free-running period counter; pulses o_tick on the cycle the count wraps to 0.
module pwm_seq_tick #(
    parameter int unsigned BITS = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic [BITS-1:0] i_period,
    output logic            o_tick
);

    logic [BITS-1:0] r_cnt;
    logic [BITS-1:0] r_period;
    logic            w_run;
    logic            w_wrap;

    // A changed period holds the count at 0 for one cycle, restarting the phase.
    assign w_run  = i_en && (i_period != '0) && (i_period == r_period);
    assign w_wrap = (r_cnt == i_period - BITS'(1));
    assign o_tick = w_run && w_wrap;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_period <= '0;
        end else begin
            r_period <= i_period;
            if (!w_run || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + BITS'(1);
            end
        end
    end

endmodule

// File: rtl/wb_pwm_sequencer.sv
// Sweeps a snapshot of per-channel duty values into PWM timer compare
// registers over a Wishbone master port, on a periodic tick or software trigger.
module wb_pwm_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int unsigned     BITS      = 32,
    parameter int unsigned     CH        = 4,
    parameter logic [BITS-1:0] BASE_ADDR = BITS'(DefBaseAddr),
    parameter logic [BITS-1:0] STRIDE    = BITS'(DefStride),
    parameter logic [BITS-1:0] REG_OFF   = BITS'(DefRegOff),
    parameter int unsigned     TIMEOUT   = DefTimeout
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   en,
    input  logic [BITS-1:0]        period,
    input  logic                   sw_trig,
    input  logic [CH*BITS-1:0]     duty,
    output logic [BITS-1:0]        m_wb_adr,
    output logic [BITS-1:0]        m_wb_dat_w,
    output logic [3:0]             m_wb_sel,
    output logic                   m_wb_we,
    output logic                   m_wb_cyc,
    output logic                   m_wb_stb,
    input  logic                   m_wb_ack,
    input  logic                   m_wb_err,
    output logic                   busy,
    output logic                   done,
    output logic                   err_sticky,
    output logic [$clog2(CH)-1:0]  err_ch
);

    localparam int unsigned IW = $clog2(CH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [StW-1:0]  r_state;
    logic [StW-1:0]  w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic            r_pend;
    logic [BITS-1:0] r_snap [CH];
    logic [TW-1:0]   r_wait;
    logic            r_cyc;
    logic [BITS-1:0] r_adr;
    logic [BITS-1:0] r_dat;
    logic            r_err;
    logic [IW-1:0]   r_err_ch;

    logic            w_tick;
    logic            w_trig;
    logic            w_timeout;
    logic            w_term;
    logic            w_fail;
    logic            w_last;
    logic [BITS-1:0] w_adr;

    pwm_seq_tick #(
        .BITS (BITS)
    ) u_tick (
        .i_clk    (wb_clk_i),
        .i_rst    (wb_rst_i),
        .i_en     (en),
        .i_period (period),
        .o_tick   (w_tick)
    );

    assign w_trig    = w_tick || sw_trig;
    assign w_timeout = (r_wait == TW'(TIMEOUT - 1));
    assign w_term    = m_wb_ack || m_wb_err || w_timeout;
    // err wins over a simultaneous ack; an ack on the last wait cycle still counts.
    assign w_fail    = m_wb_err || (w_timeout && !m_wb_ack);
    assign w_last    = (r_idx == IW'(CH - 1));
    assign w_adr     = BASE_ADDR + BITS'(r_idx) * STRIDE + REG_OFF;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (w_trig) w_state_nxt = StLatch;
            StLatch: w_state_nxt = StReq;
            StReq:   w_state_nxt = StWait;
            StWait:  if (w_term) w_state_nxt = StNext;
            StNext:  w_state_nxt = w_last ? StDone : StReq;
            StDone:  w_state_nxt = (r_pend || w_trig) ? StLatch : StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= StIdle;
            r_idx    <= '0;
            r_pend   <= 1'b0;
            r_wait   <= '0;
            r_cyc    <= 1'b0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_err    <= 1'b0;
            r_err_ch <= '0;
            for (int i = 0; i < CH; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;

            case (r_state)
                StLatch: begin
                    for (int i = 0; i < CH; i++) begin
                        r_snap[i] <= duty[i*BITS +: BITS];
                    end
                    r_idx <= '0;
                end
                StReq: begin
                    r_cyc  <= 1'b1;
                    r_adr  <= w_adr;
                    r_dat  <= r_snap[r_idx];
                    r_wait <= '0;
                end
                StWait: begin
                    if (w_term) begin
                        r_cyc <= 1'b0;
                        r_adr <= '0;
                        r_dat <= '0;
                        if (w_fail) begin
                            r_err    <= 1'b1;
                            r_err_ch <= r_idx;
                        end
                    end else begin
                        r_wait <= r_wait + TW'(1);
                    end
                end
                StNext: begin
                    if (!w_last) r_idx <= r_idx + IW'(1);
                end
                default: ;
            endcase

            // Triggers during a sweep collapse into one pending request, consumed at DONE.
            if (r_state == StDone) begin
                r_pend <= 1'b0;
            end else if (r_state != StIdle && w_trig) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign m_wb_cyc   = r_cyc;
    assign m_wb_stb   = r_cyc;
    assign m_wb_we    = r_cyc;
    assign m_wb_sel   = {4{r_cyc}};
    assign m_wb_adr   = r_adr;
    assign m_wb_dat_w = r_dat;
    assign busy       = (r_state != StIdle);
    assign done       = (r_state == StDone);
    assign err_sticky = r_err;
    assign err_ch     = r_err_ch;

endmodule

// File: tb/tb_wb_pwm_sequencer.sv
// Scoreboard bench for wb_pwm_sequencer: expected writes are queued per sweep
// from the address-map rules and popped by a monitor on every acked write.
module tb_wb_pwm_sequencer;

    localparam logic [31:0] TbBase   = 32'h3000_0000;
    localparam logic [31:0] TbStride = 32'h0000_1000;
    localparam logic [31:0] TbOff    = 32'h0000_0008;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [31:0]  period;
    logic         sw_trig;
    logic [127:0] duty;
    logic [31:0]  m_wb_adr;
    logic [31:0]  m_wb_dat_w;
    logic [3:0]   m_wb_sel;
    logic         m_wb_we;
    logic         m_wb_cyc;
    logic         m_wb_stb;
    logic         m_wb_ack;
    logic         m_wb_err;
    logic         busy;
    logic         done;
    logic         err_sticky;
    logic [1:0]   err_ch;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc_cnt  = 0;
    int    done_cnt = 0;
    wr_t   exp_q[$];

    logic        s_rand      = 1'b0;
    logic        s_noack_en  = 1'b0;
    logic [31:0] s_noack_adr = '0;
    logic        s_err_en    = 1'b0;
    logic [31:0] s_err_adr   = '0;
    int          s_wcnt      = 0;
    int          s_lat       = 0;

    wb_pwm_sequencer dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .en         (en),
        .period     (period),
        .sw_trig    (sw_trig),
        .duty       (duty),
        .m_wb_adr   (m_wb_adr),
        .m_wb_dat_w (m_wb_dat_w),
        .m_wb_sel   (m_wb_sel),
        .m_wb_we    (m_wb_we),
        .m_wb_cyc   (m_wb_cyc),
        .m_wb_stb   (m_wb_stb),
        .m_wb_ack   (m_wb_ack),
        .m_wb_err   (m_wb_err),
        .busy       (busy),
        .done       (done),
        .err_sticky (err_sticky),
        .err_ch     (err_ch)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Slave: zero-wait or random-latency ack, with per-address no-ack / err faults.
    assign m_wb_ack = m_wb_cyc && m_wb_stb && !(s_noack_en && m_wb_adr == s_noack_adr)
                      && (!s_rand || s_wcnt >= s_lat);
    assign m_wb_err = m_wb_cyc && m_wb_stb && s_err_en && (m_wb_adr == s_err_adr);

    always @(posedge clk) begin
        if (m_wb_cyc && m_wb_stb && !m_wb_ack && !m_wb_err) begin
            s_wcnt <= s_wcnt + 1;
        end else begin
            s_wcnt <= 0;
            if (m_wb_ack || m_wb_err) s_lat <= $urandom_range(0, 3);
        end
    end

    function automatic logic [31:0] ch_addr(input int n);
        return TbBase + 32'(n) * TbStride + TbOff;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired, got no event expected one (t=%0t)", name, $time);
    endtask

    task automatic push_sweep(input logic [127:0] d, input logic [3:0] skip);
        for (int n = 0; n < 4; n++) begin
            if (!skip[n]) begin
                wr_t w;
                w.adr = ch_addr(n);
                w.dat = d[n*32 +: 32];
                exp_q.push_back(w);
            end
        end
    endtask

    // Monitor samples mid-low-phase; the main thread samples slightly later.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && done) done_cnt++;
            if (!rst && m_wb_cyc && m_wb_stb && m_wb_ack && !m_wb_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_adr", m_wb_adr, 0);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("write_adr", m_wb_adr, w.adr);
                    chk("write_dat", m_wb_dat_w, w.dat);
                    chk("write_sel_we", {m_wb_sel, m_wb_we}, 5'h1F);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic pulse_trig(output int t);
        t = cyc_cnt;
        sw_trig = 1'b1;
        step();
        sw_trig = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            if (done) begin
                at = cyc_cnt;
                break;
            end
            step();
        end
        if (at < 0) fail_bound(name);
    endtask

    task automatic wait_req(input string name, input logic [31:0] a, input int budget);
        bit found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (m_wb_cyc && m_wb_adr == a) begin
                found = 1'b1;
                break;
            end
            step();
        end
        if (!found) fail_bound(name);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, td, td1, td2, td3, d0, cnt;

        rst = 1'b1; en = 1'b0; period = '0; sw_trig = 1'b0; duty = '0;
        step(); step(); step();
        chk("rst_cyc", m_wb_cyc, 0);
        chk("rst_stb_we_sel", {m_wb_stb, m_wb_we, m_wb_sel}, 0);
        chk("rst_adr_dat", {m_wb_adr, m_wb_dat_w}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_err", {err_sticky, err_ch}, 0);
        rst = 1'b0;
        step();

        // Software trigger with period 0, zero-wait slave; duty altered mid-sweep.
        duty = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        push_sweep(duty, 4'b0000);
        pulse_trig(t0);
        step();
        chk("busy_during_sweep", busy, 1);
        duty = ~duty;
        wait_done("latency_done", 60, td);
        chk("trig_to_done_latency", td - t0, 14);
        step();
        chk("idle_after_done", busy, 0);
        chk("queue_after_latency", exp_q.size(), 0);

        // Random duties and slave latencies, duty rewritten after the snapshot.
        s_rand = 1'b1;
        d0 = done_cnt;
        for (int it = 0; it < 8; it++) begin
            duty = {$urandom, $urandom, $urandom, $urandom};
            push_sweep(duty, 4'b0000);
            pulse_trig(t0);
            step();
            step();
            duty = {$urandom, $urandom, $urandom, $urandom};
            wait_done("random_done", 120, td);
            step();
        end
        chk("random_sweep_count", done_cnt - d0, 8);
        chk("random_queue_empty", exp_q.size(), 0);
        chk("random_no_err", err_sticky, 0);
        s_rand = 1'b0;

        // Retriggers while busy collapse into one back-to-back sweep.
        d0 = done_cnt;
        duty = {32'd40, 32'd30, 32'd20, 32'd10};
        push_sweep(duty, 4'b0000);
        push_sweep(duty, 4'b0000);
        pulse_trig(t0);
        step(); step();
        for (int p = 0; p < 3; p++) begin
            sw_trig = 1'b1;
            step();
            sw_trig = 1'b0;
            step();
        end
        wait_done("retrig_first", 60, td1);
        chk("retrig_first_latency", td1 - t0, 14);
        step();
        chk("retrig_busy_after_done", busy, 1);
        wait_done("retrig_second", 60, td2);
        chk("retrig_gap", td2 - td1, 14);
        repeat (40) step();
        chk("retrig_sweep_count", done_cnt - d0, 2);
        chk("retrig_idle", busy, 0);
        chk("retrig_queue_empty", exp_q.size(), 0);

        // Periodic sweeps every 100 clocks.
        d0 = done_cnt;
        duty = {32'd4, 32'd3, 32'd2, 32'd1};
        push_sweep(duty, 4'b0000);
        push_sweep(duty, 4'b0000);
        push_sweep(duty, 4'b0000);
        period = 32'd100;
        en = 1'b1;
        wait_done("period_first", 300, td1);
        step();
        wait_done("period_second", 150, td2);
        chk("period_gap1", td2 - td1, 100);
        step();
        wait_done("period_third", 150, td3);
        chk("period_gap2", td3 - td2, 100);
        en = 1'b0;
        repeat (250) step();
        chk("period_stop_count", done_cnt - d0, 3);
        chk("period_queue_empty", exp_q.size(), 0);
        period = '0;

        // Channel 2 never acked: timeout, sweep continues to channel 3.
        do_reset();
        s_noack_en = 1'b1;
        s_noack_adr = ch_addr(2);
        duty = {$urandom, $urandom, $urandom, $urandom};
        push_sweep(duty, 4'b0100);
        pulse_trig(t0);
        wait_req("timeout_req", ch_addr(2), 40);
        cnt = 0;
        while (m_wb_cyc && cnt < 40) begin
            cnt++;
            step();
        end
        chk("timeout_cyc_cycles", cnt, 16);
        wait_done("timeout_done", 40, td);
        chk("timeout_err_sticky", err_sticky, 1);
        chk("timeout_err_ch", err_ch, 2);
        chk("timeout_queue_empty", exp_q.size(), 0);
        s_noack_en = 1'b0;
        step();
        push_sweep(duty, 4'b0000);
        pulse_trig(t0);
        wait_done("sticky_done", 60, td);
        step();
        chk("err_sticky_holds", err_sticky, 1);

        // ack together with err on channel 1 counts as an error.
        s_err_en = 1'b1;
        s_err_adr = ch_addr(1);
        push_sweep(duty, 4'b0010);
        pulse_trig(t0);
        wait_done("err_done", 60, td);
        step();
        chk("ack_err_err_ch", err_ch, 1);
        chk("ack_err_queue_empty", exp_q.size(), 0);
        s_err_en = 1'b0;
        do_reset();
        chk("reset_clears_err", {err_sticky, err_ch}, 0);

        // Reset while waiting on channel 1 aborts the sweep with no done.
        s_noack_en = 1'b1;
        s_noack_adr = ch_addr(1);
        push_sweep(duty, 4'b1110);
        pulse_trig(t0);
        wait_req("abort_req", ch_addr(1), 40);
        step();
        step();
        d0 = done_cnt;
        rst = 1'b1;
        step();
        chk("abort_cyc_stb", {m_wb_cyc, m_wb_stb}, 0);
        chk("abort_busy", busy, 0);
        rst = 1'b0;
        repeat (30) step();
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_queue_empty", exp_q.size(), 0);
        s_noack_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_pwm_sequencer.md
WB_PWM_SEQUENCER -- requirements
Module: wb_pwm_sequencer

Interface
REQ-001 SHALL have parameter BITS, default 32, meaning Wishbone address/data width.
REQ-002 SHALL have parameter CH, default 4, meaning number of PWM timer channels sequenced.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h3000_0000, meaning address of channel 0 timer window.
REQ-004 SHALL have parameter STRIDE, default 32'h0000_1000, meaning address step between channel windows.
REQ-005 SHALL have parameter REG_OFF, default 32'h0000_0008, meaning offset of the compare (duty) register within a window.
REQ-006 SHALL have parameter TIMEOUT, default 16, meaning maximum wait cycles for ack/err.
REQ-007 wb_clk_i  in  1  sole clock; one clock, all logic rising-edge.
REQ-008 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-009 en  in  1  sequencer enable; low holds the period counter at 0.
REQ-010 period  in  BITS  update period in clocks; 0 means only sw_trig starts a sweep.
REQ-011 sw_trig  in  1  single-cycle request for an immediate sweep.
REQ-012 duty  in  CH*BITS  duty values; slice n targets channel n.
REQ-013 m_wb_adr / m_wb_dat_w / m_wb_sel / m_wb_we / m_wb_cyc / m_wb_stb  out  BITS/BITS/4/1/1/1  Wishbone master request.
REQ-014 m_wb_ack / m_wb_err  in  1/1  Wishbone termination.
REQ-015 busy  out  1  sweep in progress.
REQ-016 done  out  1  one-cycle pulse at end of each sweep.
REQ-017 err_sticky  out  1  set on any err or timeout; cleared only by reset.
REQ-018 err_ch  out  $clog2(CH)  channel of the most recent failure.

Function
REQ-019 FSM states SHALL be IDLE, LATCH, REQ, WAIT, NEXT, DONE.
REQ-020 Period counter SHALL count 0..period-1 while en=1 and period!=0; a tick SHALL occur at wrap to 0.
REQ-021 IDLE -> LATCH on tick or sw_trig; both in the same cycle SHALL start one sweep only.
REQ-022 Triggers arriving while busy SHALL be latched as one pending flag and start a new sweep the cycle after DONE; additional triggers SHALL be dropped.
REQ-023 LATCH SHALL snapshot all of duty in one cycle; changes to duty during a sweep SHALL NOT affect it.
REQ-024 REQ SHALL drive cyc=stb=we=1, sel=4'hF, adr=BASE_ADDR+n*STRIDE+REG_OFF, dat_w=snapshot slice n; enter WAIT the same cycle.
REQ-025 Request signals SHALL remain stable until ack, err or timeout, and SHALL drop to 0 in the cycle after termination.
REQ-026 Ack SHALL advance to NEXT; err, or TIMEOUT cycles without termination, SHALL set err_sticky, load err_ch=n, and advance to NEXT (sweep continues).
REQ-027 ack and err in the same cycle SHALL be treated as err.
REQ-028 NEXT: n<CH-1 -> n+1, REQ; n=CH-1 -> DONE; DONE pulses done for one cycle, then IDLE.
REQ-029 Minimum sweep latency with zero-wait ack SHALL be 2+3*CH clocks from trigger to done (14 for CH=4).
REQ-030 Deasserting en mid-sweep SHALL NOT abort the sweep; only reset aborts.
REQ-031 Period counter SHALL restart from 0 when period changes value.

Reset
REQ-032 On wb_rst_i=1 at a clock edge: state IDLE, n=0, counter 0, pending 0, all m_wb_* outputs 0, busy 0, done 0, err_sticky 0, err_ch 0.
REQ-033 Reset mid-transaction SHALL drop cyc/stb in the next cycle with no completion.

Structure
REQ-034 State encoding, default BASE_ADDR/STRIDE/REG_OFF and TIMEOUT SHALL live in shared package pwm_seq_pkg.
REQ-035 The period counter/tick generator SHALL be sub-module pwm_seq_tick; the rest SHALL be one FSM module.

Verification
REQ-036 period=100, en=1, duty={4,3,2,1}, zero-wait ack -> writes 0x3000_0008=1, 0x3000_1008=2, 0x3000_2008=3, 0x3000_3008=4; done every 100 clocks.
REQ-037 period=0, sw_trig pulse -> one sweep, done exactly 14 clocks after trigger.
REQ-038 Slave never acks channel 2 -> cyc drops after 16 wait cycles, err_sticky=1, err_ch=2, channel 3 still written.
REQ-039 Three sw_trig pulses during a sweep -> exactly one extra sweep, starting the cycle after done.
REQ-040 wb_rst_i asserted while WAIT on channel 1 -> next cycle cyc=stb=0, busy=0, no done pulse.
REQ-041 duty changed mid-sweep -> written values equal the snapshot taken at LATCH.
